// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter in front of a single RAM slave.
// Optional stall timeout with DRAIN state is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic        s_instr_o
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wb_arbiter_2m: TIMEOUT must be in 1..255");
    end

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, DRAIN = 2'd3} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_e;
`endif

    state_e state_q, state_d;
    logic   last_q, last_d;   // 1 = m1 was granted last
    logic   req0, req1, own0, own1, tmo;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign own0 = (state_q == GNT0);
    assign own1 = (state_q == GNT1);

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       stall;

    assign stall = ((own0 & m0_stb_i) | (own1 & m1_stb_i)) & ~s_ack_i;
    // Fires on the stalled cycle that brings the count up to TIMEOUT.
    assign tmo   = stall & (cnt_q == TMO_LAST);

    always_comb begin
        cnt_d = 8'd0;
        if ((own0 || own1) && state_d == state_q) begin
            if (stall)         cnt_d = cnt_q + 8'd1;
            else if (!s_ack_i) cnt_d = cnt_q;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) state_d = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                else if (tmo)  state_d = DRAIN;
`endif
            end
            GNT1: begin
                if (!m1_cyc_i) state_d = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                else if (tmo)  state_d = DRAIN;
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            // last_q still names the aborted owner; wait for it to let go of cyc.
            DRAIN: if (!(last_q ? m1_cyc_i : m0_cyc_i)) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Everything is forced low while reset is asserted, even mid-grant.
    always_comb begin
        s_adr_o   = 32'd0;
        s_dat_o   = 32'd0;
        s_sel_o   = 4'd0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_instr_o = 1'b0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_err_o  = 1'b0;
        m0_dat_o  = 32'd0;
        m1_dat_o  = 32'd0;
        if (wb_rst_ni) begin
            m0_dat_o = s_dat_i;
            m1_dat_o = s_dat_i;
            if (own0) begin
                s_adr_o   = m0_adr_i;
                s_dat_o   = m0_dat_i;
                s_sel_o   = m0_sel_i;
                s_we_o    = m0_we_i;
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i;
                s_instr_o = 1'b1;
                m0_ack_o  = s_ack_i & ~tmo;
                m0_err_o  = tmo;
            end else if (own1) begin
                s_adr_o   = m1_adr_i;
                s_dat_o   = m1_dat_i;
                s_sel_o   = m1_sel_i;
                s_we_o    = m1_we_i;
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i;
                m1_ack_o  = s_ack_i & ~tmo;
                m1_err_o  = tmo;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: RAM slave model, grant-ownership reference
// model, directed scenarios and a randomized run. Define WB_ARB_TIMEOUT_EN for the timeout test.
module tb_wb_arbiter_2m;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_wdat[2];
    logic [3:0]  m_sel [2];

    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_instr_o;
    logic        s_ack;
    logic [31:0] s_rdat;

    wb_arbiter_2m #(.TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack), .s_dat_i(s_rdat),
        .s_instr_o(s_instr_o)
    );

    // RAM slave: one ack per strobe, one cycle after it is seen.
    logic [31:0] mem [64];
    logic        mem_clr = 1'b0;
    logic        no_ack  = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) begin
            s_ack  <= 1'b0;
            s_rdat <= 32'd0;
        end else begin
            if (mem_clr) for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
            s_ack <= 1'b0;
            if (s_cyc_o && s_stb_o && !s_ack && !no_ack) begin
                s_ack  <= 1'b1;
                s_rdat <= mem[s_adr_o[7:2]];
                if (s_we_o)
                    for (int b = 0; b < 4; b++)
                        if (s_sel_o[b]) mem[s_adr_o[7:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
            end
        end
    end

    // Reference model of ownership: -1 nobody, 0/1 the granted master, 2 aborted (drain).
    int mown = -1, mlast = 1, mcnt = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            mown = -1; mlast = 1; mcnt = 0;
        end else if (mown == -1) begin
            if (m_cyc[0] && m_stb[0] && m_cyc[1] && m_stb[1]) mown = 1 - mlast;
            else if (m_cyc[0] && m_stb[0])                   mown = 0;
            else if (m_cyc[1] && m_stb[1])                   mown = 1;
            if (mown >= 0) mlast = mown;
        end else if (mown == 2) begin
            if (!m_cyc[mlast]) mown = -1;
        end else if (!m_cyc[mown]) begin
            mown = -1; mcnt = 0;
        end else if (m_stb[mown] && !s_ack) begin
`ifdef WB_ARB_TIMEOUT_EN
            if (mcnt == TMO - 1) begin mown = 2; mcnt = 0; end
            else mcnt++;
`endif
        end else if (s_ack) begin
            mcnt = 0;
        end
    end

    int tests = 0, fails = 0;

    task automatic tick; @(negedge clk); endtask

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        m_cyc[m] = cyc; m_stb[m] = stb; m_we[m] = we;
        m_adr[m] = adr; m_wdat[m] = dat; m_sel[m] = sel;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0;
        set_m(0, 0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0, 0);
        tick; tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [167:0] allv;
        rst_n = 1'b0;
        set_m(0, 1, 1, 1, 32'h44, 32'hdead_beef, 4'hf);
        set_m(1, 1, 1, 0, 32'h48, 32'h1, 4'hf);
        tick; tick;
        allv = {s_cyc_o, s_stb_o, s_we_o, s_instr_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
                s_adr_o, s_dat_o, s_sel_o, m0_dat_o, m1_dat_o};
        tests++;
        if (allv !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", allv); end
        reset_dut;
    endtask

    task automatic test_tie_after_reset;
        logic got;
        reset_dut;
        set_m(0, 1, 1, 0, 32'h100, 0, 4'hf);
        set_m(1, 1, 1, 0, 32'h104, 0, 4'hf);
        tick;
        tests++;
        if ({s_cyc_o, s_stb_o, s_instr_o} !== 3'b111 || s_adr_o !== 32'h100) begin
            fails++; $display("FAIL tie_gnt0: cyc/stb/instr=%b adr=%h want 111 adr=00000100",
                              {s_cyc_o, s_stb_o, s_instr_o}, s_adr_o);
        end
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (m0_ack_o) begin got = 1'b1; break; end
            tick;
        end
        tests++;
        if (!got || m1_ack_o !== 1'b0) begin
            fails++; $display("FAIL tie_m0_ack: m0_ack=%b m1_ack=%b want 1 0", got, m1_ack_o);
        end
        set_m(0, 0, 0, 0, 0, 0, 0);
        tick;
        tests++;
        if ({s_cyc_o, s_instr_o} !== 2'b00) begin
            fails++; $display("FAIL tie_idle_gap: cyc/instr=%b want 00", {s_cyc_o, s_instr_o});
        end
        tick;
        tests++;
        if ({s_cyc_o, s_instr_o} !== 2'b10 || s_adr_o !== 32'h104) begin
            fails++; $display("FAIL tie_gnt1: cyc/instr=%b adr=%h want 10 adr=00000104",
                              {s_cyc_o, s_instr_o}, s_adr_o);
        end
        tick;
        set_m(1, 0, 0, 0, 0, 0, 0);
        tick;
    endtask

    task automatic test_owner_atomic;
        int acks = 0;
        logic got = 1'b0;
        reset_dut;
        set_m(1, 1, 1, 0, 32'h80, 0, 4'hf);
        tick;
        set_m(0, 1, 1, 0, 32'h84, 0, 4'hf);
        for (int c = 0; c < 60 && acks < 3; c++) begin
            tick;
            tests++;
            if (m0_ack_o !== 1'b0 || s_instr_o !== 1'b0) begin
                fails++; $display("FAIL atomic_m0_held: m0_ack=%b instr=%b want 0 0", m0_ack_o, s_instr_o);
            end
            if (m1_ack_o) begin acks++; m_stb[1] = 1'b0; end
            else m_stb[1] = 1'b1;
        end
        tests++;
        if (acks != 3) begin fails++; $display("FAIL atomic_m1_acks: got %0d want 3", acks); end
        set_m(1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            tick;
            if (m0_ack_o) begin got = 1'b1; break; end
        end
        tests++;
        if (!got) begin fails++; $display("FAIL atomic_m0_served: m0_ack=0 want 1"); end
        set_m(0, 0, 0, 0, 0, 0, 0);
        tick;
    endtask

    task automatic test_write_read;
        logic got = 1'b0;
        logic [31:0] rd = 32'd0, rd0 = 32'd0;
        reset_dut;
        mem_clr = 1'b1; tick; mem_clr = 1'b0;
        set_m(0, 1, 1, 1, 32'h40, 32'h1234_5678, 4'b0011);
        for (int c = 0; c < 10; c++) begin
            tick;
            if (m0_ack_o) begin got = 1'b1; break; end
        end
        set_m(0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (!got) begin fails++; $display("FAIL wr_m0_ack: m0_ack=0 want 1"); end
        tick;
        set_m(1, 1, 1, 0, 32'h40, 0, 4'hf);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (m1_ack_o) begin got = 1'b1; rd = m1_dat_o; rd0 = m0_dat_o; break; end
        end
        set_m(1, 0, 0, 0, 0, 0, 0);
        tests++;
        if (!got || rd !== 32'h0000_5678 || rd0 !== 32'h0000_5678) begin
            fails++; $display("FAIL rd_m1_data: ack=%b m1_dat=%h m0_dat=%h want 1 00005678", got, rd, rd0);
        end
        tick;
    endtask

    task automatic test_alternate;
        int grants[8];
        int n = 0;
        logic prev = 1'b0;
        reset_dut;
        set_m(0, 1, 1, 0, 32'h0, 0, 4'hf);
        set_m(1, 1, 1, 0, 32'h4, 0, 4'hf);
        for (int c = 0; c < 300 && n < 8; c++) begin
            tick;
            if (s_cyc_o && !prev) begin grants[n] = s_instr_o ? 0 : 1; n++; end
            prev = s_cyc_o;
            for (int m = 0; m < 2; m++) begin
                if ((m == 0) ? m0_ack_o : m1_ack_o) begin m_cyc[m] = 1'b0; m_stb[m] = 1'b0; end
                else if (!m_cyc[m]) begin m_cyc[m] = 1'b1; m_stb[m] = 1'b1; end
            end
        end
        tests++;
        if (n != 8) begin fails++; $display("FAIL alt_count: got %0d grants want 8", n); end
        for (int i = 0; i < n; i++) begin
            tests++;
            if (grants[i] != i % 2) begin
                fails++; $display("FAIL alt_grant%0d: got m%0d want m%0d", i, grants[i], i % 2);
            end
        end
        set_m(0, 0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0, 0);
        tick; tick;
    endtask

    task automatic test_random;
        logic [6:0]  got_c, exp_c;
        logic [68:0] got_b, exp_b;
        int o;
        logic e;
        reset_dut;
        for (int c = 0; c < 400; c++) begin
            tick;
            o = (mown == 0 || mown == 1) ? mown : -1;
            e = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            if (o >= 0) e = m_cyc[o] && m_stb[o] && !s_ack && (mcnt == TMO - 1);
`endif
            got_c = {s_cyc_o, s_stb_o, s_instr_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o};
            exp_c = {o >= 0 && m_cyc[o], o >= 0 && m_stb[o], o == 0,
                     o == 0 && s_ack && !e, o == 1 && s_ack && !e, o == 0 && e, o == 1 && e};
            tests++;
            if (got_c !== exp_c) begin
                fails++; $display("FAIL rand_ctrl cyc%0d: got %b want %b", c, got_c, exp_c);
            end
            got_b = {s_adr_o, s_dat_o, s_sel_o, s_we_o};
            exp_b = (o >= 0) ? {m_adr[o], m_wdat[o], m_sel[o], m_we[o]} : '0;
            tests++;
            if (got_b !== exp_b) begin
                fails++; $display("FAIL rand_bus cyc%0d: got %h want %h", c, got_b, exp_b);
            end
            tests++;
            if (m0_dat_o !== s_rdat || m1_dat_o !== s_rdat) begin
                fails++; $display("FAIL rand_rdat cyc%0d: got %h/%h want %h", c, m0_dat_o, m1_dat_o, s_rdat);
            end
            for (int m = 0; m < 2; m++) begin
                if (m_cyc[m]) m_cyc[m] = ($urandom % 4) != 0;
                else          m_cyc[m] = ($urandom % 3) == 0;
                m_stb[m]  = m_cyc[m] && (($urandom % 4) != 0);
                m_we[m]   = $urandom % 2;
                m_adr[m]  = {24'd0, 6'($urandom), 2'b00};
                m_wdat[m] = $urandom;
                m_sel[m]  = 4'($urandom);
            end
        end
        set_m(0, 0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0, 0);
        tick; tick;
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout;
        logic got = 1'b0;
        reset_dut;
        no_ack = 1'b1;
        set_m(1, 1, 1, 0, 32'h10, 0, 4'hf);
        for (int k = 1; k <= 4; k++) begin
            tick;
            tests++;
            if (m1_err_o !== (k == 4) || s_cyc_o !== 1'b1 || m1_ack_o !== 1'b0) begin
                fails++; $display("FAIL tmo_stall%0d: err=%b cyc=%b ack=%b want %b 1 0",
                                  k, m1_err_o, s_cyc_o, m1_ack_o, k == 4);
            end
        end
        tick;
        tests++;
        if ({s_cyc_o, s_stb_o, m1_err_o, m1_ack_o} !== 4'b0000) begin
            fails++; $display("FAIL tmo_drain: cyc/stb/err/ack=%b want 0000", {s_cyc_o, s_stb_o, m1_err_o, m1_ack_o});
        end
        set_m(0, 1, 1, 0, 32'h20, 0, 4'hf);
        tick;
        tests++;
        if ({s_cyc_o, s_instr_o} !== 2'b00) begin
            fails++; $display("FAIL tmo_drain_hold: cyc/instr=%b want 00", {s_cyc_o, s_instr_o});
        end
        set_m(1, 0, 0, 0, 0, 0, 0);
        tick;
        tests++;
        if (s_cyc_o !== 1'b0) begin fails++; $display("FAIL tmo_idle: cyc=%b want 0", s_cyc_o); end
        tick;
        tests++;
        if ({s_cyc_o, s_instr_o} !== 2'b11) begin
            fails++; $display("FAIL tmo_regrant: cyc/instr=%b want 11", {s_cyc_o, s_instr_o});
        end
        no_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (m0_ack_o) begin got = 1'b1; break; end
        end
        tests++;
        if (!got) begin fails++; $display("FAIL tmo_m0_ack: m0_ack=0 want 1"); end
        set_m(0, 0, 0, 0, 0, 0, 0);
        tick;
    endtask
`endif

    task automatic test_reset_mid_grant;
        logic [167:0] allv;
        reset_dut;
        set_m(1, 1, 1, 1, 32'h60, 32'hcafe_f00d, 4'hf);
        tick;
        tests++;
        if ({s_cyc_o, s_instr_o} !== 2'b10) begin
            fails++; $display("FAIL rstmid_gnt1: cyc/instr=%b want 10", {s_cyc_o, s_instr_o});
        end
        rst_n = 1'b0;
        #1;
        allv = {s_cyc_o, s_stb_o, s_we_o, s_instr_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
                s_adr_o, s_dat_o, s_sel_o, m0_dat_o, m1_dat_o};
        tests++;
        if (allv !== '0) begin fails++; $display("FAIL rstmid_during: got %h want 0", allv); end
        tick;
        allv = {s_cyc_o, s_stb_o, s_we_o, s_instr_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
                s_adr_o, s_dat_o, s_sel_o, m0_dat_o, m1_dat_o};
        tests++;
        if (allv !== '0) begin fails++; $display("FAIL rstmid_after: got %h want 0", allv); end
        set_m(1, 1, 1, 0, 32'h64, 0, 4'hf);
        set_m(0, 1, 1, 0, 32'h68, 0, 4'hf);
        rst_n = 1'b1;
        tick;
        tests++;
        if ({s_cyc_o, s_instr_o} !== 2'b11 || s_adr_o !== 32'h68) begin
            fails++; $display("FAIL rstmid_tie_m0: cyc/instr=%b adr=%h want 11 adr=00000068",
                              {s_cyc_o, s_instr_o}, s_adr_o);
        end
        set_m(0, 0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0, 0);
        tick; tick;
    endtask

    initial begin
        set_m(0, 0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0, 0);
        test_reset;
        test_tie_after_reset;
        test_owner_atomic;
        test_write_read;
        test_alternate;
        test_random;
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout;
`endif
        test_reset_mid_grant;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the number of stalled cycles before a cycle is aborted (legal range 1..255; only used with WB_ARB_TIMEOUT_EN).
REQ-002 The block SHALL have port wb_clk_i, input, 1 bit: the only clock.
REQ-003 The block SHALL have port wb_rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have ports m0_adr_i[31:0], m0_dat_i[31:0], m0_sel_i[3:0], m0_we_i, m0_cyc_i and m0_stb_i, all inputs: master 0 (instruction fetch) request.
REQ-005 The block SHALL have outputs m0_ack_o (1), m0_err_o (1) and m0_dat_o (32): master 0 response.
REQ-006 The block SHALL have ports m1_* with the same set, directions and widths as REQ-004/005: master 1 (data) port.
REQ-007 The block SHALL have outputs s_adr_o[31:0], s_dat_o[31:0], s_sel_o[3:0], s_we_o, s_cyc_o and s_stb_o: the shared slave (RAM) request.
REQ-008 The block SHALL have inputs s_ack_i (1) and s_dat_i (32): the slave response.
REQ-009 The block SHALL have output s_instr_o (1): high while master 0 owns the slave; it drives the RAM's mem_instr input.

Function
REQ-010 The block SHALL implement registered states IDLE, GNT0 and GNT1, plus DRAIN when WB_ARB_TIMEOUT_EN is defined.
REQ-011 In IDLE the block SHALL treat mN as requesting when mN_cyc_i & mN_stb_i is high.
REQ-012 In IDLE with a single requester, the block SHALL move to that requester's GNT state on the next edge.
REQ-013 In IDLE with both masters requesting, the block SHALL grant the master that does not match the registered last-granted pointer (round-robin).
REQ-014 The last-granted pointer SHALL update on every entry to GNT0 or GNT1.
REQ-015 Request-to-slave latency SHALL be one cycle: a request seen in IDLE at edge N gives s_cyc_o/s_stb_o high after edge N.
REQ-016 In GNTx the block SHALL drive s_adr_o, s_dat_o, s_sel_o, s_we_o and s_stb_o combinationally from master x, and s_cyc_o from mx_cyc_i.
REQ-017 In IDLE and DRAIN the block SHALL hold s_cyc_o and s_stb_o at 0.
REQ-018 In IDLE and DRAIN, s_adr_o, s_dat_o, s_sel_o and s_we_o SHALL be 0.
REQ-019 In GNTx the block SHALL set mx_ack_o = s_ack_i; the other master's ack SHALL be 0.
REQ-020 mN_dat_o SHALL equal s_dat_i for both masters at all times.
REQ-021 The owner SHALL keep the grant for as long as its cyc is high, so back-to-back stb pulses inside one cyc stay atomic.
REQ-022 In GNTx with mx_cyc_i low, the block SHALL return to IDLE; there is always at least one IDLE cycle between grants.
REQ-023 A request from the non-owner SHALL be held off without an ack until the owner releases, and SHALL NOT be lost.
REQ-024 s_instr_o SHALL be high only in GNT0.

Reset
REQ-025 While wb_rst_ni is sampled low on an edge, the block SHALL enter IDLE, set the last-granted pointer to 1 (so m0 wins the first tie) and clear the timeout counter.
REQ-026 During reset all outputs SHALL be 0, including m0_err_o and m1_err_o.
REQ-027 A reset during GNTx SHALL drop s_cyc_o after that edge, with no ack or err delivered.

Configuration
REQ-028 The macro WB_ARB_TIMEOUT_EN SHALL control the timeout feature.
REQ-029 With WB_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL increment each GNTx cycle in which s_stb_o is high and s_ack_i is low, and clear on s_ack_i or on leaving GNTx.
REQ-030 With WB_ARB_TIMEOUT_EN defined, when the counter equals TIMEOUT, mx_err_o SHALL pulse for exactly one cycle, the ack SHALL be suppressed and the state SHALL become DRAIN.
REQ-031 With WB_ARB_TIMEOUT_EN defined, DRAIN SHALL return to IDLE once mx_cyc_i is low.
REQ-032 Without WB_ARB_TIMEOUT_EN, the counter and DRAIN SHALL be absent, mN_err_o SHALL be tied 0, and grants wait indefinitely.

Verification
REQ-033 Bench: m0 and m1 both request at the same edge straight after reset -> GNT0 first, s_instr_o=1; after m0 drops cyc, one IDLE cycle, then GNT1.
REQ-034 Bench: m1 holds cyc across 3 stb/ack transfers while m0 requests -> m0_ack_o stays 0 throughout; m0 is served after m1 releases.
REQ-035 Bench: m0 writes 0x1234_5678 with sel=4'b0011 to 0x40, then m1 reads 0x40 -> m1_dat_o=0x0000_5678 with m1_ack_o, assuming RAM initialised to 0.
REQ-036 Bench: alternating continuous requests from both masters over 8 grants -> grants strictly alternate m0,m1,...
REQ-037 Bench: WB_ARB_TIMEOUT_EN, TIMEOUT=4, slave never acks -> m1_err_o single pulse on the 4th stalled cycle, s_cyc_o=0 next cycle, IDLE after m1 drops cyc.
REQ-038 Bench: wb_rst_ni=0 mid-GNT1 -> next cycle all outputs 0 and state IDLE; a later simultaneous request is granted to m0.
